// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: bundle between the ID/EX stage and the hazard scoreboard.
// The master side (pipeline) drives the EX instruction description, the per-stage
// results and branch resolution. The slave side (scoreboard) returns stall, flush,
// operand forwarding and the stall counter.
interface hazard_scoreboard_if #(
    parameter int DW    = 24,
    parameter int AW    = 4,
    parameter int NSRC  = 3,
    parameter int DEPTH = 2
);
    logic                  ex_valid;
    logic [NSRC*AW-1:0]    ex_src;
    logic [NSRC-1:0]       ex_src_used;
    logic                  ex_wr;
    logic [AW-1:0]         ex_rd;
    logic                  ex_load;
    logic [DEPTH*DW-1:0]   stage_data;
    logic                  branch_taken;
    logic                  stall;
    logic                  flush;
    logic [NSRC-1:0]       fwd_en;
    logic [NSRC*DW-1:0]    fwd_data;
    logic [31:0]           stall_cnt;

    modport master (
        output ex_valid, ex_src, ex_src_used, ex_wr, ex_rd, ex_load,
               stage_data, branch_taken,
        input  stall, flush, fwd_en, fwd_data, stall_cnt
    );

    modport slave (
        input  ex_valid, ex_src, ex_src_used, ex_wr, ex_rd, ex_load,
               stage_data, branch_taken,
        output stall, flush, fwd_en, fwd_data, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destination tags of in-flight instructions over DEPTH
// post-EX stages and resolves operand hazards for the instruction sitting in EX.
// Produces the global stall, per-operand forward selects/data, the branch flush
// and a saturating stall-cycle counter.
//
// Build option: define HZD_BYPASS_EN to enable forwarding from the tracked stages.
// Without it, fwd_en/fwd_data are held at zero and any matching producer stalls
// EX until it has retired out of stage DEPTH (the register file is write-through).
module hazard_scoreboard #(
    parameter int DW         = 24,
    parameter int AW         = 4,
    parameter int NSRC       = 3,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   hz
);

    // Tag pipeline state: index 0 is stage 1 (EX/MEM), index DEPTH-1 is MEM/WB.
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] wr_q,    wr_d;
    logic [DEPTH-1:0] load_q,  load_d;
    logic [AW-1:0]    rd_q [DEPTH];
    logic [AW-1:0]    rd_d [DEPTH];

    logic [31:0]      stall_cnt_q, stall_cnt_d;

    // Per-operand resolution results.
    logic [NSRC-1:0]    op_hit;     // youngest matching producer exists
    logic [NSRC-1:0]    op_ready;   // that producer's value is available
    logic [NSRC*DW-1:0] op_data;    // that producer's stage result
    logic [NSRC-1:0]    op_haz;     // operand cannot proceed this cycle
    logic [NSRC-1:0]    op_fwd;     // operand is served from a stage

    logic stall_c;
    logic enter_c;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_op
            logic [AW-1:0] src;
            logic          hit;
            logic          ready;
            logic [DW-1:0] data;

            assign src = hz.ex_src[gi*AW +: AW];

            // Scan oldest to youngest so the youngest (lowest stage) match wins.
            always_comb begin
                hit   = 1'b0;
                ready = 1'b0;
                data  = '0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (hz.ex_valid && hz.ex_src_used[gi] &&
                        valid_q[k] && wr_q[k] && (rd_q[k] == src)) begin
                        hit   = 1'b1;
                        // Loads only have data from LOAD_STAGE onward.
                        ready = !load_q[k] || ((k + 1) >= LOAD_STAGE);
                        data  = hz.stage_data[k*DW +: DW];
                    end
                end
            end

            assign op_hit[gi]             = hit;
            assign op_ready[gi]           = ready;
            assign op_data[gi*DW +: DW]   = data;

`ifdef HZD_BYPASS_EN
            assign op_haz[gi]             = hit && !ready;
            assign op_fwd[gi]             = hit && ready;
            assign hz.fwd_data[gi*DW +: DW] = op_fwd[gi] ? data : '0;
`else
            // Without bypass any in-flight producer blocks the read until it retires.
            assign op_haz[gi]             = hit;
            assign op_fwd[gi]             = 1'b0;
            assign hz.fwd_data[gi*DW +: DW] = '0;
`endif
        end
    endgenerate

`ifndef HZD_BYPASS_EN
    // Readiness and stage data only matter when forwarding is built in.
    logic unused_nobypass;
    assign unused_nobypass = ^{op_ready, op_data};
`endif

    // A taken branch kills EX, so it never waits on operands.
    assign stall_c = (|op_haz) && !hz.branch_taken;
    assign enter_c = hz.ex_valid && !stall_c && !hz.branch_taken;

    assign hz.stall     = stall_c;
    assign hz.flush     = hz.branch_taken;
    assign hz.fwd_en    = op_fwd;
    assign hz.stall_cnt = stall_cnt_q;

    // Next tag-pipeline contents: EX (or a bubble) into stage 1, older stages shift.
    always_comb begin
        valid_d   = '0;
        wr_d      = '0;
        load_d    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rd_d[k] = '0;
        end
        valid_d[0] = enter_c;
        wr_d[0]    = hz.ex_wr;
        load_d[0]  = hz.ex_load;
        rd_d[0]    = hz.ex_rd;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            wr_d[k]    = wr_q[k-1];
            load_d[k]  = load_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
    end

    // Tag pipeline registers; stage DEPTH drops off the end (retires) each clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            wr_q    <= '0;
            load_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= rd_d[k];
            end
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios for hazard_scoreboard with a
// history-based reference model checked every cycle, plus literal expectations
// for the key scenario points. Follows HZD_BYPASS_EN the same way as the design.
module tb_hazard_scoreboard;
    localparam int DW         = 24;
    localparam int AW         = 4;
    localparam int NSRC       = 3;
    localparam int DEPTH      = 2;
    localparam int LOAD_STAGE = 2;
    localparam int OUTW       = 2 + NSRC + NSRC*DW;
    localparam int PADW       = 128 - OUTW;

    logic clk;
    logic rst;

    hazard_scoreboard_if #(.DW(DW), .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH)) bus ();

    hazard_scoreboard #(
        .DW(DW), .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    // hist[j] describes what entered stage 1 j+1 clocks ago, i.e. stage j+1 now.
    typedef struct packed {
        logic          valid;
        logic          wr;
        logic          load;
        logic [AW-1:0] rd;
    } ent_t;

    typedef struct packed {
        logic               stall;
        logic               flush;
        logic [NSRC-1:0]    fwd_en;
        logic [NSRC*DW-1:0] fwd_data;
    } exp_t;

    ent_t        hist[$];
    logic [31:0] m_cnt = '0;

    function automatic exp_t model_eval();
        exp_t          e;
        logic          haz;
        logic          found;
        ent_t          s;
        logic [AW-1:0] src;
        e       = '0;
        haz     = 1'b0;
        e.flush = bus.branch_taken;
        for (int i = 0; i < NSRC; i++) begin
            src   = bus.ex_src[i*AW +: AW];
            found = 1'b0;
            if (bus.ex_valid && bus.ex_src_used[i]) begin
                for (int k = 1; k <= DEPTH; k++) begin
                    if (!found && k <= hist.size()) begin
                        s = hist[k-1];
                        if (s.valid && s.wr && s.rd == src) begin
                            found = 1'b1;
`ifdef HZD_BYPASS_EN
                            if (!s.load || k >= LOAD_STAGE) begin
                                e.fwd_en[i] = 1'b1;
                                e.fwd_data[i*DW +: DW] = bus.stage_data[(k-1)*DW +: DW];
                            end else begin
                                haz = 1'b1;
                            end
`else
                            haz = 1'b1;
`endif
                        end
                    end
                end
            end
        end
        e.stall = haz && !bus.branch_taken;
        return e;
    endfunction

    function automatic logic model_stall();
        exp_t e;
        e = model_eval();
        return e.stall;
    endfunction

    function automatic ent_t make_entry();
        ent_t n;
        n.valid = bus.ex_valid && !model_stall() && !bus.branch_taken;
        n.wr    = bus.ex_wr;
        n.load  = bus.ex_load;
        n.rd    = bus.ex_rd;
        return n;
    endfunction

    // Model advance on each clock (or clear on reset).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            m_cnt <= '0;
        end else begin
            if (model_stall() && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
            hist.push_front(make_entry());
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        check("outputs",
              {{PADW{1'b0}}, bus.stall, bus.flush, bus.fwd_en, bus.fwd_data},
              {{PADW{1'b0}}, model_eval()});
        check("stall_cnt", 128'(bus.stall_cnt), 128'(m_cnt));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex();
        bus.ex_valid     = 1'b0;
        bus.ex_src       = '0;
        bus.ex_src_used  = '0;
        bus.ex_wr        = 1'b0;
        bus.ex_rd        = '0;
        bus.ex_load      = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic drive_writer(input logic [AW-1:0] rd, input logic ld);
        bus.ex_valid    = 1'b1;
        bus.ex_wr       = 1'b1;
        bus.ex_load     = ld;
        bus.ex_rd       = rd;
        bus.ex_src      = '0;
        bus.ex_src_used = '0;
    endtask

    task automatic drive_reader(input int op, input logic [AW-1:0] rs);
        bus.ex_valid            = 1'b1;
        bus.ex_wr               = 1'b0;
        bus.ex_load             = 1'b0;
        bus.ex_rd               = '0;
        bus.ex_src              = '0;
        bus.ex_src_used         = '0;
        bus.ex_src[op*AW +: AW] = rs;
        bus.ex_src_used[op]     = 1'b1;
    endtask

    task automatic set_data(input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        bus.stage_data = {d2, d1};
    endtask

    task automatic drain();
        idle_ex();
        repeat (DEPTH + 1) tick();
    endtask

    // Called at a negedge; holds EX until the stall clears, bounded by budget.
    task automatic hold_until_free(input int budget);
        int n = 0;
        while (bus.stall && n < budget) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("stall_released", 128'(bus.stall), 128'(0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1;
        idle_ex();
        set_data('0, '0);
        repeat (2) tick();
        @(negedge clk);
        check("rst_stall",     128'(bus.stall),     128'(0));
        check("rst_fwd_en",    128'(bus.fwd_en),    128'(0));
        check("rst_stall_cnt", 128'(bus.stall_cnt), 128'(0));
        tick();
        rst = 1'b0;
        tick();

        // Stage 1 writes R1; EX reads R1 on operand 0.
        drive_writer(4'd1, 1'b0);
        set_data(24'h00ABCD, 24'h000000);
        tick();
        drive_reader(0, 4'd1);
        @(negedge clk);
`ifdef HZD_BYPASS_EN
        check("t1_fwd_en",   128'(bus.fwd_en),         128'(3'b001));
        check("t1_fwd_data", 128'(bus.fwd_data[0 +: DW]), 128'(24'h00ABCD));
        check("t1_stall",    128'(bus.stall),          128'(0));
        tick();
`else
        check("t1_stall_c1", 128'(bus.stall),  128'(1));
        check("t1_fwd_en",   128'(bus.fwd_en), 128'(0));
        tick();
        @(negedge clk);
        check("t1_stall_c2", 128'(bus.stall),  128'(1));
        tick();
        @(negedge clk);
        check("t1_stall_c3", 128'(bus.stall),  128'(0));
        tick();
`endif
        drain();

        // Load R2 into stage 1; EX reads R2 as Rb.
        drive_writer(4'd2, 1'b1);
        tick();
        drive_reader(1, 4'd2);
        set_data(24'h000000, 24'h123456);
        @(negedge clk);
        check("t2_stall_c1", 128'(bus.stall),  128'(1));
        check("t2_fwd_en_c1", 128'(bus.fwd_en), 128'(0));
        tick();
        @(negedge clk);
`ifdef HZD_BYPASS_EN
        check("t2_stall_c2",  128'(bus.stall),             128'(0));
        check("t2_fwd_en_c2", 128'(bus.fwd_en),            128'(3'b010));
        check("t2_fwd_data",  128'(bus.fwd_data[DW +: DW]), 128'(24'h123456));
        check("t2_stall_cnt", 128'(bus.stall_cnt),         128'(1));
        tick();
`else
        check("t2_stall_c2",  128'(bus.stall),     128'(1));
        check("t2_stall_cnt", 128'(bus.stall_cnt), 128'(3));
        tick();
        @(negedge clk);
        check("t2_stall_c3",  128'(bus.stall),     128'(0));
        tick();
`endif
        drain();

        // Stages 1 and 2 both write R3; youngest wins.
        drive_writer(4'd3, 1'b0);
        tick();
        tick();
        drive_reader(2, 4'd3);
        set_data(24'h000001, 24'h000002);
        @(negedge clk);
`ifdef HZD_BYPASS_EN
        check("t3_fwd_en",   128'(bus.fwd_en),                128'(3'b100));
        check("t3_fwd_data", 128'(bus.fwd_data[2*DW +: DW]),  128'(24'h000001));
        check("t3_stall",    128'(bus.stall),                 128'(0));
        tick();
`else
        check("t3_stall",    128'(bus.stall),  128'(1));
        hold_until_free(8);
`endif
        drain();

        // Taken branch kills an EX writer of R4.
        drive_writer(4'd4, 1'b0);
        bus.branch_taken = 1'b1;
        @(negedge clk);
        check("t4_flush", 128'(bus.flush), 128'(1));
        check("t4_stall", 128'(bus.stall), 128'(0));
        tick();
        bus.branch_taken = 1'b0;
        drive_reader(0, 4'd4);
        set_data(24'h111111, 24'h222222);
        @(negedge clk);
        check("t4_reader_fwd_en", 128'(bus.fwd_en), 128'(0));
        check("t4_reader_stall",  128'(bus.stall),  128'(0));
        check("t4_reader_flush",  128'(bus.flush),  128'(0));
        tick();
        drain();

        // Load-use hazard coinciding with a taken branch: flush wins.
        drive_writer(4'd6, 1'b1);
        tick();
        drive_reader(0, 4'd6);
        bus.branch_taken = 1'b1;
        @(negedge clk);
        check("t4b_stall", 128'(bus.stall), 128'(0));
        check("t4b_flush", 128'(bus.flush), 128'(1));
        tick();
        bus.branch_taken = 1'b0;
        @(negedge clk);
        hold_until_free(8);
        drain();

        // Reset in the middle of a load-use stall.
        drive_writer(4'd7, 1'b1);
        tick();
        drive_reader(0, 4'd7);
        set_data(24'h0A0A0A, 24'h0B0B0B);
        @(negedge clk);
        check("t5_stall_before", 128'(bus.stall), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_stall",     128'(bus.stall),     128'(0));
        check("t5_rst_fwd_en",    128'(bus.fwd_en),    128'(0));
        check("t5_rst_fwd_data",  128'(bus.fwd_data),  128'(0));
        check("t5_rst_stall_cnt", 128'(bus.stall_cnt), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_after_fwd_en", 128'(bus.fwd_en), 128'(0));
        check("t5_after_stall",  128'(bus.stall),  128'(0));
        tick();
        drain();

        // Stage 1 writes R5; EX reads R5.
        drive_writer(4'd5, 1'b0);
        tick();
        drive_reader(0, 4'd5);
        set_data(24'h055555, 24'h000000);
        @(negedge clk);
`ifdef HZD_BYPASS_EN
        check("t6_fwd_en",   128'(bus.fwd_en),            128'(3'b001));
        check("t6_fwd_data", 128'(bus.fwd_data[0 +: DW]), 128'(24'h055555));
        check("t6_stall",    128'(bus.stall),             128'(0));
        tick();
`else
        check("t6_stall_c1", 128'(bus.stall),  128'(1));
        tick();
        @(negedge clk);
        check("t6_stall_c2", 128'(bus.stall),  128'(1));
        tick();
        @(negedge clk);
        check("t6_stall_c3", 128'(bus.stall),  128'(0));
        check("t6_fwd_en",   128'(bus.fwd_en), 128'(0));
        tick();
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
